// File: rtl/program_loader.sv
// program_loader: boot stage that receives a byte stream (valid/ready),
// assembles little-endian 32-bit instruction words and 64-bit data doublewords,
// writes them through the core's external memory ports, then enables the core.
// Stream: NI[15:0] LE, ND[15:0] LE, NI x 4 instruction bytes, ND x 8 data bytes.
// Optional build macro LOADER_CHECKSUM_EN: a trailing byte C must make the
// mod-256 sum of all stream bytes (header through last data byte) plus C zero.
module program_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        soft_clear,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        done,
  output logic        error
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BCNT_W = 3;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned HDR_W  = 24;
  localparam int unsigned WREG_W = 56;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HDR, ST_IMEM, ST_DMEM, ST_FIN, ST_RUN, ST_ERR, ST_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_HDR, ST_IMEM, ST_DMEM, ST_FIN, ST_RUN, ST_ERR
  } state_t;
`endif

  state_t              state;
  logic [BCNT_W-1:0]   bcnt;
  logic [CNT_W-1:0]    icnt;
  logic [CNT_W-1:0]    dcnt;
  logic [CNT_W-1:0]    ni;
  logic [CNT_W-1:0]    nd;
  logic [HDR_W-1:0]    hdr;
  logic [WREG_W-1:0]   wreg;
  logic                xfer;
  logic [CNT_W-1:0]    hdr_ni;
  logic [CNT_W-1:0]    hdr_nd;
  logic                hdr_bad;

  // Read strobes are never used by the loader.
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;

  // Byte handshake and header decode as seen on the 4th header byte.
  assign xfer    = s_valid & s_ready;
  assign hdr_ni  = hdr[15:0];
  assign hdr_nd  = {s_data, hdr[23:16]};
  assign hdr_bad = (32'(hdr_ni) > IMEM_WORDS) || (32'(hdr_nd) > DMEM_WORDS);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;

  // Running mod-256 sum of every header and payload byte.
  always_ff @(posedge clk) begin
    if (!arst_n || soft_clear) begin
      sum <= '0;
    end else if (xfer && (state == ST_HDR || state == ST_IMEM || state == ST_DMEM)) begin
      sum <= sum + s_data;
    end
  end
`endif

  // Load sequencer: header parse, word assembly, write strobes, core enable.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state       <= ST_HDR;
      bcnt        <= '0;
      icnt        <= '0;
      dcnt        <= '0;
      ni          <= '0;
      nd          <= '0;
      hdr         <= '0;
      wreg        <= '0;
      s_ready     <= 1'b1;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      cpu_enable  <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (soft_clear) begin
      // Any concurrent byte is dropped; memory outputs keep their last value.
      state      <= ST_HDR;
      bcnt       <= '0;
      icnt       <= '0;
      dcnt       <= '0;
      s_ready    <= 1'b1;
      wen_ext    <= 1'b0;
      wen_ext_2  <= 1'b0;
      cpu_enable <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      case (state)
        ST_HDR: begin
          if (xfer) begin
            hdr <= {s_data, hdr[HDR_W-1:8]};
            if (bcnt == BCNT_W'(3)) begin
              bcnt <= '0;
              ni   <= hdr_ni;
              nd   <= hdr_nd;
              if (hdr_bad) begin
                state   <= ST_ERR;
                s_ready <= 1'b0;
                error   <= 1'b1;
              end else if (hdr_ni != '0) begin
                state <= ST_IMEM;
              end else if (hdr_nd != '0) begin
                state <= ST_DMEM;
              end else begin
                state   <= ST_FIN;
                s_ready <= 1'b0;
              end
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end

        ST_IMEM: begin
          if (xfer) begin
            wreg <= {s_data, wreg[WREG_W-1:8]};
            if (bcnt == BCNT_W'(3)) begin
              bcnt      <= '0;
              wen_ext   <= 1'b1;
              addr_ext  <= ADDR_W'({icnt, 2'b00});
              wdata_ext <= {s_data, wreg[WREG_W-1:32]};
              icnt      <= icnt + CNT_W'(1);
              if (icnt + CNT_W'(1) == ni) begin
                if (nd != '0) begin
                  state <= ST_DMEM;
                end else begin
                  state   <= ST_FIN;
                  s_ready <= 1'b0;
                end
              end
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end

        ST_DMEM: begin
          if (xfer) begin
            wreg <= {s_data, wreg[WREG_W-1:8]};
            if (bcnt == BCNT_W'(7)) begin
              bcnt        <= '0;
              wen_ext_2   <= 1'b1;
              addr_ext_2  <= ADDR_W'({dcnt, 3'b000});
              wdata_ext_2 <= {s_data, wreg};
              dcnt        <= dcnt + CNT_W'(1);
              if (dcnt + CNT_W'(1) == nd) begin
                state   <= ST_FIN;
                s_ready <= 1'b0;
              end
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        ST_FIN: begin
          state   <= ST_CSUM;
          s_ready <= 1'b1;
        end

        ST_CSUM: begin
          if (xfer) begin
            s_ready <= 1'b0;
            if (sum + s_data == 8'd0) begin
              state      <= ST_RUN;
              cpu_enable <= 1'b1;
              done       <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`else
        ST_FIN: begin
          state      <= ST_RUN;
          cpu_enable <= 1'b1;
          done       <= 1'b1;
        end
`endif

        ST_RUN: begin
          state <= ST_RUN;
        end

        ST_ERR: begin
          state <= ST_ERR;
        end

        default: begin
          state   <= ST_HDR;
          s_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
